// File: rtl/first_set_finder_pipelined_if.sv
// Handshake bundle for first_set_finder_pipelined: search vector in, lowest-set index out.
// FFS_MASK_EN adds a per-bit search mask sampled alongside the vector.
interface first_set_finder_pipelined_if #(
    parameter int WIDTH = 13
);
    localparam int IDXW = $clog2(WIDTH);

    logic [WIDTH-1:0] in;
    logic             validIn;
`ifdef FFS_MASK_EN
    logic [WIDTH-1:0] mask;
`endif
    logic [IDXW-1:0]  index;
    logic             found;
    logic             validOut;

`ifdef FFS_MASK_EN
    modport master (output in, validIn, mask, input index, found, validOut);
    modport slave  (input in, validIn, mask, output index, found, validOut);
`else
    modport master (output in, validIn, input index, found, validOut);
    modport slave  (input in, validIn, output index, found, validOut);
`endif
endinterface

// File: rtl/first_set_finder_pipelined.sv
// Pipelined radix-4 find-first-set: each stage picks the lowest nonzero quarter and emits 2 index bits.
// Optional FFS_MASK_EN ANDs a mask into the input stage; latency is unchanged.
module first_set_finder_pipelined #(
    parameter int WIDTH = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    first_set_finder_pipelined_if.slave   bus
);
    localparam int IDXW   = $clog2(WIDTH);
    localparam int STAGES = ($clog2(WIDTH) + 1) / 2;
    localparam int PW     = 1 << (2 * STAGES);
    localparam int IW     = 2 * STAGES;

    logic [PW-1:0]   vec_s;
    logic [IDXW-1:0] index_r;
    logic            found_r;
    logic            valid_r;

    // Zero-pad the (optionally masked) input up to a whole power of four
    always_comb begin
        vec_s = '0;
`ifdef FFS_MASK_EN
        vec_s[WIDTH-1:0] = bus.in & bus.mask;
`else
        vec_s[WIDTH-1:0] = bus.in;
`endif
    end

    for (genvar g = 0; g < STAGES; g++) begin : stg
        localparam int S  = STAGES - 1 - g;
        localparam int GW = 1 << (2 * S);

        logic [4*GW-1:0] din_s;
        logic            vin_s;
        logic [IW-1:0]   pin_s;
        logic [3:0]      flag_s;
        logic [1:0]      sel_s;
        logic [IW-1:0]   pout_s;

        if (g == 0) begin : src
            assign din_s = vec_s;
            assign vin_s = bus.validIn;
            assign pin_s = '0;
        end else begin : link
            assign din_s = stg[g-1].pipe.data_r;
            assign vin_s = stg[g-1].pipe.v_r;
            assign pin_s = stg[g-1].pipe.idx_r;
        end

        // Group-nonzero flags for the four groups of this stage
        always_comb begin
            for (int k = 0; k < 4; k++) begin
                flag_s[k] = |din_s[k*GW +: GW];
            end
        end

        // Lowest nonzero group wins; an all-zero vector resolves to group 0
        always_comb begin
            if (flag_s[0]) begin
                sel_s = 2'd0;
            end else if (flag_s[1]) begin
                sel_s = 2'd1;
            end else if (flag_s[2]) begin
                sel_s = 2'd2;
            end else if (flag_s[3]) begin
                sel_s = 2'd3;
            end else begin
                sel_s = 2'd0;
            end
        end

        assign pout_s = pin_s | (IW'(sel_s) << (2 * S));

        if (S > 0) begin : pipe
            logic [GW-1:0] data_r;
            logic [IW-1:0] idx_r;
            logic          v_r;

            // Valid bit is cleared by reset; data and partial index need no reset
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_r <= 1'b0;
                end else begin
                    v_r <= vin_s;
                end
                data_r <= din_s[sel_s*GW +: GW];
                idx_r  <= pout_s;
            end
        end else begin : last
            // Output register: bubbles and reset present index=0, found=0
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_r <= 1'b0;
                    found_r <= 1'b0;
                    index_r <= '0;
                end else if (vin_s) begin
                    valid_r <= 1'b1;
                    found_r <= |flag_s;
                    index_r <= pout_s[IDXW-1:0];
                end else begin
                    valid_r <= 1'b0;
                    found_r <= 1'b0;
                    index_r <= '0;
                end
            end
        end
    end

    assign bus.index    = index_r;
    assign bus.found    = found_r;
    assign bus.validOut = valid_r;
endmodule
